spi_clockgen: RTL and testbench

SPI_CLOCKGEN -- requirements
Module: spi_clockgen

---
 rtl/spi_clockgen_pkg.sv | 9 +
 rtl/spi_clockgen.sv | 73 +++++++
 tb/tb_spi_clockgen.sv | 139 +++++++++++++
 3 files changed

// File: rtl/spi_clockgen_pkg.sv
// Shared SPI width constants, used by the clock generator and the SPI top.
package spi_clockgen_pkg;

   localparam int SPI_DIVIDER_LEN   = 16;
   localparam int SPI_MAX_CHAR      = 128;
   localparam int SPI_CHAR_LEN_BITS = 7;
   localparam int SPI_SS_NB         = 8;

endpackage : spi_clockgen_pkg

// File: rtl/spi_clockgen.sv
// SPI serial clock generator: divides wb_clk_in into sclk_out and produces
// one-cycle strobes ahead of each rising (cpol_0) and falling (cpol_1) edge.
// All outputs come straight from flops; no input reaches an output combinationally.
module spi_clockgen
   import spi_clockgen_pkg::*;
#(
   parameter int DIVIDER_LEN = SPI_DIVIDER_LEN
) (
   input  logic                   wb_clk_in,
   input  logic                   wb_rst,
   input  logic                   go,
   input  logic                   tip,
   input  logic                   last_clk,
   input  logic [DIVIDER_LEN-1:0] divider,
   output logic                   sclk_out,
   output logic                   cpol_0,
   output logic                   cpol_1
);

   logic [DIVIDER_LEN-1:0] cnt_q, cnt_d;
   logic                   sclk_q, sclk_d;
   logic                   cpol0_q, cpol0_d;
   logic                   cpol1_q, cpol1_d;
   logic                   cnt_zero, cnt_one, div_zero;

   assign cnt_zero = (cnt_q == '0);
   assign cnt_one  = (cnt_q == DIVIDER_LEN'(1));
   assign div_zero = (divider == '0);

   // Next-state: counter reload/decrement, sclk toggle, edge strobes.
   always_comb begin
      cnt_d   = cnt_q;
      sclk_d  = sclk_q;
      cpol0_d = 1'b0;
      cpol1_d = 1'b0;

      // Reloading whenever idle means a divider change lands only at a reload.
      if (cnt_zero || !tip)
         cnt_d = divider;
      else
         cnt_d = cnt_q - DIVIDER_LEN'(1);

      // During the last bit a high clock may still fall, but a low one stays low.
      if (tip && cnt_zero && (!last_clk || sclk_q))
         sclk_d = ~sclk_q;

      cpol0_d = (tip & ~sclk_q & cnt_one) |
                (div_zero & sclk_q) |
                (div_zero & go & ~tip);
      cpol1_d = (tip & sclk_q & cnt_one) |
                (div_zero & ~sclk_q & tip);
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge wb_clk_in) begin
      if (!wb_rst) begin
         cnt_q   <= '1;
         sclk_q  <= 1'b0;
         cpol0_q <= 1'b0;
         cpol1_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         sclk_q  <= sclk_d;
         cpol0_q <= cpol0_d;
         cpol1_q <= cpol1_d;
      end
   end

   assign sclk_out = sclk_q;
   assign cpol_0   = cpol0_q;
   assign cpol_1   = cpol1_q;

endmodule : spi_clockgen

// File: tb/tb_spi_clockgen.sv
// Directed bench for spi_clockgen with hand-computed expected values.
module tb_spi_clockgen;
   import spi_clockgen_pkg::*;

   logic                       wb_clk_in;
   logic                       wb_rst;
   logic                       go;
   logic                       tip;
   logic                       last_clk;
   logic [SPI_DIVIDER_LEN-1:0] divider;
   logic                       sclk_out;
   logic                       cpol_0;
   logic                       cpol_1;

   int checks = 0;
   int errors = 0;

   spi_clockgen #(.DIVIDER_LEN(SPI_DIVIDER_LEN)) dut (
      .wb_clk_in (wb_clk_in),
      .wb_rst    (wb_rst),
      .go        (go),
      .tip       (tip),
      .last_clk  (last_clk),
      .divider   (divider),
      .sclk_out  (sclk_out),
      .cpol_0    (cpol_0),
      .cpol_1    (cpol_1)
   );

   initial wb_clk_in = 1'b0;
   always #5 wb_clk_in = ~wb_clk_in;

   // Advance one rising edge, then settle before sampling.
   task automatic step();
      @(posedge wb_clk_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic s, input logic c0, input logic c1);
      chk({tag, ".sclk"},   32'(sclk_out), 32'(s));
      chk({tag, ".cpol_0"}, 32'(cpol_0),   32'(c0));
      chk({tag, ".cpol_1"}, 32'(cpol_1),   32'(c1));
   endtask

   initial begin
      wb_rst   = 1'b0;
      go       = 1'b0;
      tip      = 1'b0;
      last_clk = 1'b0;
      divider  = 16'd1;

      // Reset held two cycles
      step();
      step();
      chk_out("rst", 1'b0, 1'b0, 1'b0);
      chk("rst.cnt", 32'(dut.cnt_q), 32'h0000_FFFF);

      // Idle cycle loads the divider
      wb_rst = 1'b1;
      step();
      chk("idle.cnt", 32'(dut.cnt_q), 32'd1);
      chk_out("idle", 1'b0, 1'b0, 1'b0);

      // divider=1: period 4, strobes one cycle ahead of each edge
      tip = 1'b1;
      step(); chk_out("d1.e1", 1'b0, 1'b1, 1'b0);
      step(); chk_out("d1.e2", 1'b1, 1'b0, 1'b0);
      step(); chk_out("d1.e3", 1'b1, 1'b0, 1'b1);
      step(); chk_out("d1.e4", 1'b0, 1'b0, 1'b0);
      step(); chk_out("d1.e5", 1'b0, 1'b1, 1'b0);
      step(); chk_out("d1.e6", 1'b1, 1'b0, 1'b0);

      // tip dropped for 3 cycles: sclk frozen high, counter holds divider
      tip = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_out("pause", 1'b1, 1'b0, 1'b0);
         chk("pause.cnt", 32'(dut.cnt_q), 32'd1);
      end
      tip = 1'b1;
      step(); chk_out("resume.e1", 1'b1, 1'b0, 1'b1);
      step(); chk_out("resume.e2", 1'b0, 1'b0, 1'b0);

      // divider raised to 3 mid-transfer: picked up at next reload
      divider = 16'd3;
      step(); chk_out("div3.e1", 1'b0, 1'b1, 1'b0);
      step(); chk_out("div3.e2", 1'b1, 1'b0, 1'b0);
      chk("div3.cnt", 32'(dut.cnt_q), 32'd3);

      // last_clk with sclk high: one falling edge, then stays low
      last_clk = 1'b1;
      step(); chk_out("last.e1", 1'b1, 1'b0, 1'b0);
      step(); chk_out("last.e2", 1'b1, 1'b0, 1'b0);
      step(); chk_out("last.e3", 1'b1, 1'b0, 1'b1);
      step(); chk_out("last.e4", 1'b0, 1'b0, 1'b0);
      for (int i = 5; i <= 12; i++) begin
         step();
         chk("last.hold", 32'(sclk_out), 32'd0);
      end

      // Release last_clk and run to a high phase
      last_clk = 1'b0;
      step(); step(); step();
      chk_out("run.e3", 1'b0, 1'b1, 1'b0);
      step();
      chk_out("run.e4", 1'b1, 1'b0, 1'b0);

      // Reset mid-transfer with sclk high
      wb_rst = 1'b0;
      step();
      chk_out("midrst", 1'b0, 1'b0, 1'b0);
      chk("midrst.cnt", 32'(dut.cnt_q), 32'h0000_FFFF);

      // divider=0: go with tip low strobes cpol_0, then clock toggles every cycle
      wb_rst  = 1'b1;
      divider = 16'd0;
      go      = 1'b1;
      tip     = 1'b0;
      step(); chk_out("d0.go", 1'b0, 1'b1, 1'b0);
      go  = 1'b0;
      tip = 1'b1;
      step(); chk_out("d0.e1", 1'b1, 1'b0, 1'b1);
      step(); chk_out("d0.e2", 1'b0, 1'b1, 1'b0);
      step(); chk_out("d0.e3", 1'b1, 1'b0, 1'b1);
      step(); chk_out("d0.e4", 1'b0, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_spi_clockgen
